// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the D-stage hazard scoreboard: Tuse/Tnew defaults,
// mult/div start codes, forward-select stage numbering and latency lookup.
package hazard_scoreboard_pkg;

  localparam int unsigned N_STG_DEF    = 3;
  localparam int unsigned TW_DEF       = 2;
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  // fwd_*_sel: 0 = register file, otherwise the stage index the value comes from
  localparam int unsigned FWD_GRF = 0;
  localparam int unsigned FWD_E   = 1;
  localparam int unsigned FWD_M   = 2;
  localparam int unsigned FWD_W   = 3;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_RSVD = 2'b11
  } md_start_e;

  // Busy length for a mult/div start code; the reserved code behaves as no start.
  function automatic int unsigned md_lat(input logic [1:0] start,
                                         input int unsigned mult_lat,
                                         input int unsigned div_lat);
    case (start)
      MD_MULT: md_lat = mult_lat;
      MD_DIV:  md_lat = div_lat;
      default: md_lat = 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_hz_match.sv
// Finds the youngest in-flight write to one source register and reports whether
// its remaining Tnew exceeds the reader's Tuse.
module hz_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned N_STG = N_STG_DEF,
  parameter int unsigned TW    = TW_DEF,
  parameter int unsigned SW    = $clog2(N_STG + 1)
) (
  input  logic [4:0]                  rx_i,
  input  logic [TW-1:0]               tuse_i,
  input  logic [N_STG-1:0]            rec_vld_i,
  input  logic [N_STG-1:0][4:0]       rec_waddr_i,
  input  logic [N_STG-1:0][TW-1:0]    rec_tnew_i,
  output logic                        hit_o,
  output logic [SW-1:0]               k_o,
  output logic [TW-1:0]               tnew_o,
  output logic                        hz_o
);

  always_comb begin
    hit_o  = 1'b0;
    k_o    = '0;
    tnew_o = '0;
    // Index 0 is the youngest record (E); first hit wins so older records are masked.
    for (int unsigned i = 0; i < N_STG; i++) begin
      if (!hit_o && (rx_i != 5'd0) && rec_vld_i[i] && (rec_waddr_i[i] == rx_i)) begin
        hit_o  = 1'b1;
        k_o    = SW'(i + 1);
        tnew_o = rec_tnew_i[i];
      end
    end
    hz_o = hit_o && (tuse_i != '1) && (tnew_o > tuse_i);
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Stall/forward controller: tracks in-flight register writes with countdown Tnew,
// resolves D-stage operand hazards and the HI/LO mult/div busy interlock.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned N_STG    = N_STG_DEF,
  parameter int unsigned TW       = TW_DEF,
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          d_valid,
  input  logic [4:0]                    d_rs,
  input  logic [4:0]                    d_rt,
  input  logic [TW-1:0]                 d_tuse_rs,
  input  logic [TW-1:0]                 d_tuse_rt,
  input  logic [4:0]                    d_waddr,
  input  logic [TW-1:0]                 d_tnew,
  input  logic [1:0]                    d_md_start,
  input  logic                          d_md_use,
  input  logic                          flush,
  output logic                          stall,
  output logic [$clog2(N_STG+1)-1:0]    fwd_rs_sel,
  output logic [$clog2(N_STG+1)-1:0]    fwd_rt_sel,
  output logic                          md_busy
);

  localparam int unsigned SW     = $clog2(N_STG + 1);
  localparam int unsigned MAXLAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int unsigned CW     = $clog2(MAXLAT + 1);

  logic [N_STG-1:0]          rec_vld_q,   rec_vld_d;
  logic [N_STG-1:0][4:0]     rec_waddr_q, rec_waddr_d;
  logic [N_STG-1:0][TW-1:0]  rec_tnew_q,  rec_tnew_d;
  logic [CW-1:0]             md_cnt_q,    md_cnt_d;

  logic          rs_hit, rt_hit, hz_rs, hz_rt, hz_md, md_load;
  logic [SW-1:0] rs_k, rt_k;
  logic [TW-1:0] rs_tnew, rt_tnew;

  hz_match #(.N_STG(N_STG), .TW(TW), .SW(SW)) u_match_rs (
    .rx_i        (d_rs),
    .tuse_i      (d_tuse_rs),
    .rec_vld_i   (rec_vld_q),
    .rec_waddr_i (rec_waddr_q),
    .rec_tnew_i  (rec_tnew_q),
    .hit_o       (rs_hit),
    .k_o         (rs_k),
    .tnew_o      (rs_tnew),
    .hz_o        (hz_rs)
  );

  hz_match #(.N_STG(N_STG), .TW(TW), .SW(SW)) u_match_rt (
    .rx_i        (d_rt),
    .tuse_i      (d_tuse_rt),
    .rec_vld_i   (rec_vld_q),
    .rec_waddr_i (rec_waddr_q),
    .rec_tnew_i  (rec_tnew_q),
    .hit_o       (rt_hit),
    .k_o         (rt_k),
    .tnew_o      (rt_tnew),
    .hz_o        (hz_rt)
  );

  always_comb begin
    md_busy    = (md_cnt_q != '0);
    hz_md      = d_md_use && md_busy;
    stall      = d_valid && (hz_rs || hz_rt || hz_md);
    fwd_rs_sel = (rs_hit && (rs_tnew == '0)) ? rs_k : SW'(FWD_GRF);
    fwd_rt_sel = (rt_hit && (rt_tnew == '0)) ? rt_k : SW'(FWD_GRF);
    md_load    = d_valid && !stall && (md_lat(d_md_start, MULT_LAT, DIV_LAT) != 0);
  end

  always_comb begin
    rec_vld_d      = '0;
    rec_waddr_d    = '0;
    rec_tnew_d     = '0;
    rec_vld_d[0]   = d_valid && !stall && (d_waddr != 5'd0) && !flush;
    rec_waddr_d[0] = d_waddr;
    rec_tnew_d[0]  = d_tnew;
    for (int unsigned i = 1; i < N_STG; i++) begin
      rec_vld_d[i]   = rec_vld_q[i-1] && !flush;
      rec_waddr_d[i] = rec_waddr_q[i-1];
      rec_tnew_d[i]  = (rec_tnew_q[i-1] == '0) ? '0 : rec_tnew_q[i-1] - TW'(1);
    end
  end

  always_comb begin
    if (md_load)
      md_cnt_d = CW'(md_lat(d_md_start, MULT_LAT, DIV_LAT));
    else if (md_cnt_q != '0)
      md_cnt_d = md_cnt_q - CW'(1);
    else
      md_cnt_d = md_cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rec_vld_q   <= '0;
      rec_waddr_q <= '0;
      rec_tnew_q  <= '0;
      md_cnt_q    <= '0;
    end else begin
      rec_vld_q   <= rec_vld_d;
      rec_waddr_q <= rec_waddr_d;
      rec_tnew_q  <= rec_tnew_d;
      md_cnt_q    <= md_cnt_d;
    end
  end

endmodule
